mc_control_alu: RTL and testbench

MC_CONTROL_ALU -- requirements
Module: mc_control_alu

---
 rtl/mc_control_alu_if.sv | 58 +++++
 rtl/mc_control_alu.sv | 253 +++++++++++++++++++++++++
 tb/tb_mc_control_alu.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_alu_if.sv
// -----------------------------------------------------------------------------
// mc_control_alu_if
// Bundles the instruction fields, ALU operands and every control/ALU output of
// the multi-cycle controller into one interface.
//   master : datapath side -- drives opcode/funct3/funct7/alu_a/alu_b and
//            observes the ALU result, flags and control strobes.
//   slave  : controller side (mc_control_alu) -- the reverse directions.
// Signals:
//   opcode[6:0], funct3[2:0], funct7[6:0]  instruction fields
//   alu_a[31:0], alu_b[31:0]               externally muxed ALU operands
//   alu_result[31:0], zero, carryout, negative, overflow  ALU outputs
//   pc_write, ir_write, mem_read, mem_write, reg_write    datapath strobes
//   a_write, b_write, aluout_write, mdr_write              register enables
//   alu_src_a, alu_src_b[1:0], pc_src[1:0], result_src[1:0] mux selects
// -----------------------------------------------------------------------------
interface mc_control_alu_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] alu_a;
  logic [31:0] alu_b;

  logic [31:0] alu_result;
  logic        zero;
  logic        carryout;
  logic        negative;
  logic        overflow;

  logic        pc_write;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        a_write;
  logic        b_write;
  logic        aluout_write;
  logic        mdr_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic [1:0]  result_src;

  modport master (
    output opcode, funct3, funct7, alu_a, alu_b,
    input  alu_result, zero, carryout, negative, overflow,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
    input  a_write, b_write, aluout_write, mdr_write,
    input  alu_src_a, alu_src_b, pc_src, result_src
  );

  modport slave (
    input  opcode, funct3, funct7, alu_a, alu_b,
    output alu_result, zero, carryout, negative, overflow,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
    output a_write, b_write, aluout_write, mdr_write,
    output alu_src_a, alu_src_b, pc_src, result_src
  );
endinterface

// File: rtl/mc_control_alu.sv
// -----------------------------------------------------------------------------
// mc_control_alu
// Multi-cycle RISC-V style controller plus its combinational ALU.
// A Moore FSM sequences FETCH/DECODE/execute/writeback steps and drives the
// datapath strobes and mux selects; the ALU decodes funct3/funct7 for R- and
// I-type instructions and computes result and flags.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous, active-high reset (forces FETCH)
//   bus  : mc_control_alu_if.slave -- instruction fields and operands in,
//          ALU result/flags and all control outputs out
// -----------------------------------------------------------------------------
module mc_control_alu (
  input  logic                 clk,
  input  logic                 rst,
  mc_control_alu_if.slave      bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ctl_t;

  state_t      state_q, state_d;

  // Moore control decode
  logic [1:0]  alu_op;
  logic        pc_write_moore;
  logic        ir_write_c, mem_read_c, mem_write_c, reg_write_c;
  logic        a_write_c, b_write_c, aluout_write_c, mdr_write_c;
  logic        alu_src_a_c;
  logic [1:0]  alu_src_b_c, pc_src_c, result_src_c;

  // ALU
  alu_ctl_t    alu_ctl;
  logic [31:0] alu_res;
  logic        alu_carry, alu_ovf, alu_zero;
  logic [32:0] sum_w, diff_w;
  logic [4:0]  shamt;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    alu_op         = 2'b00;
    pc_write_moore = 1'b0;
    ir_write_c     = 1'b0;
    mem_read_c     = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    a_write_c      = 1'b0;
    b_write_c      = 1'b0;
    aluout_write_c = 1'b0;
    mdr_write_c    = 1'b0;
    alu_src_a_c    = 1'b0;
    alu_src_b_c    = 2'b00;
    pc_src_c       = 2'b10;
    result_src_c   = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        ir_write_c     = 1'b1;
        pc_write_moore = 1'b1;
        alu_src_b_c    = 2'b01;
        pc_src_c       = 2'b00;
        state_d        = S_DECODE;
      end
      S_DECODE: begin
        // PC has already been incremented, so ALUOut holds the branch/jump target.
        a_write_c      = 1'b1;
        b_write_c      = 1'b1;
        aluout_write_c = 1'b1;
        alu_src_b_c    = 2'b10;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c    = 1'b1;
        alu_src_b_c    = 2'b10;
        aluout_write_c = 1'b1;
        state_d        = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_read_c  = 1'b1;
        mdr_write_c = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        result_src_c = 2'b01;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a_c    = 1'b1;
        alu_src_b_c    = 2'b00;
        alu_op         = 2'b10;
        aluout_write_c = 1'b1;
        state_d        = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a_c    = 1'b1;
        alu_src_b_c    = 2'b10;
        alu_op         = 2'b11;
        aluout_write_c = 1'b1;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        result_src_c = 2'b00;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // pc_write is added outside this block from the ALU zero flag.
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b00;
        alu_op      = 2'b01;
        pc_src_c    = 2'b01;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        reg_write_c    = 1'b1;
        result_src_c   = 2'b10;
        pc_write_moore = 1'b1;
        pc_src_c       = 2'b01;
        state_d        = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (bus.funct3)
          // funct7[5] on funct3=000 is only meaningful for R-type; for I-type
          // those bits are immediate data.
          3'b000: alu_ctl = (alu_op == 2'b10 && bus.funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctl = ALU_SLL;
          3'b010: alu_ctl = ALU_SLT;
          3'b011: alu_ctl = ALU_SLTU;
          3'b100: alu_ctl = ALU_XOR;
          3'b101: alu_ctl = bus.funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctl = ALU_OR;
          default: alu_ctl = ALU_AND;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------------
  assign sum_w  = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign diff_w = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
  assign shamt  = bus.alu_b[4:0];

  always_comb begin
    alu_res   = 32'd0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (alu_ctl)
      ALU_ADD: begin
        alu_res   = sum_w[31:0];
        alu_carry = sum_w[32];
        alu_ovf   = (bus.alu_a[31] == bus.alu_b[31]) && (sum_w[31] != bus.alu_a[31]);
      end
      ALU_SUB: begin
        alu_res   = diff_w[31:0];
        // Bit 32 of the 33-bit difference is the borrow; carry is its inverse.
        alu_carry = ~diff_w[32];
        alu_ovf   = (bus.alu_a[31] != bus.alu_b[31]) && (diff_w[31] != bus.alu_a[31]);
      end
      ALU_SLL:  alu_res = bus.alu_a << shamt;
      ALU_SLT:  alu_res = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      ALU_SLTU: alu_res = {31'd0, (bus.alu_a < bus.alu_b)};
      ALU_XOR:  alu_res = bus.alu_a ^ bus.alu_b;
      ALU_SRL:  alu_res = bus.alu_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(bus.alu_a) >>> shamt);
      ALU_OR:   alu_res = bus.alu_a | bus.alu_b;
      ALU_AND:  alu_res = bus.alu_a & bus.alu_b;
      default:  alu_res = 32'd0;
    endcase
  end

  assign alu_zero = (alu_res == 32'd0);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.alu_result   = alu_res;
  assign bus.zero         = alu_zero;
  assign bus.carryout     = alu_carry;
  assign bus.negative     = alu_res[31];
  assign bus.overflow     = alu_ovf;

  // BEQ: the only non-Moore output, taken when the SUB in BRANCH yields zero.
  assign bus.pc_write     = pc_write_moore | ((state_q == S_BRANCH) && alu_zero);
  assign bus.ir_write     = ir_write_c;
  assign bus.mem_read     = mem_read_c;
  assign bus.mem_write    = mem_write_c;
  assign bus.reg_write    = reg_write_c;
  assign bus.a_write      = a_write_c;
  assign bus.b_write      = b_write_c;
  assign bus.aluout_write = aluout_write_c;
  assign bus.mdr_write    = mdr_write_c;
  assign bus.alu_src_a    = alu_src_a_c;
  assign bus.alu_src_b    = alu_src_b_c;
  assign bus.pc_src       = pc_src_c;
  assign bus.result_src   = result_src_c;

endmodule

// File: tb/tb_mc_control_alu.sv
// -----------------------------------------------------------------------------
// tb_mc_control_alu
// Directed instruction sequences through mc_control_alu. A bench-side model
// lists the step sequence of each instruction and derives the control word
// and ALU outputs for each step; a negedge process compares every cycle.
// Hand-computed literal expectations pin specific results.
// -----------------------------------------------------------------------------
module tb_mc_control_alu;

  typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_WB, P_BR, P_J} phase_t;
  typedef enum {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND} mop_t;

  logic clk;
  logic rst;

  mc_control_alu_if bus_if();

  mc_control_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  bit     chk_en   = 1'b0;
  phase_t exp_phase = P_F;

  // values sampled mid-step for literal checks
  logic [31:0] cap_result;
  logic        cap_zero, cap_carry, cap_ovf, cap_pcw, cap_memw, cap_mdrw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic mop_t model_op(phase_t p, logic [2:0] f3, logic [6:0] f7);
    mop_t m;
    m = M_ADD;
    if (p == P_BR) m = M_SUB;
    else if (p == P_ER || p == P_EI) begin
      case (f3)
        3'd0: m = (p == P_ER && f7[5]) ? M_SUB : M_ADD;
        3'd1: m = M_SLL;
        3'd2: m = M_SLT;
        3'd3: m = M_SLTU;
        3'd4: m = M_XOR;
        3'd5: m = f7[5] ? M_SRA : M_SRL;
        3'd6: m = M_OR;
        default: m = M_AND;
      endcase
    end
    return m;
  endfunction

  // returns {overflow, carry, result}
  function automatic logic [33:0] model_alu(mop_t m, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic c, o;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; c = 0; o = 0;
    case (m)
      M_ADD: begin
        r = a + b;
        c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      M_SUB: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      M_SLL:  r = a << b[4:0];
      M_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      M_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      M_XOR:  r = a ^ b;
      M_SRL:  r = a >> b[4:0];
      M_SRA:  r = 32'(sa >>> b[4:0]);
      M_OR:   r = a | b;
      default: r = a & b;
    endcase
    return {o, c, r};
  endfunction

  // control word: {pcw,irw,mrd,mwr,rgw,aw,bw,aow,mdrw,srca,srcb[1:0],pcsrc[1:0],ressrc[1:0]}
  function automatic logic [15:0] model_ctrl(phase_t p, logic [31:0] a, logic [31:0] b);
    logic pcw, irw, mrd, mwr, rgw, aw, bw, aow, mdrw, srca;
    logic [1:0] srcb, pcs, rs;
    pcw = 0; irw = 0; mrd = 0; mwr = 0; rgw = 0; aw = 0; bw = 0; aow = 0; mdrw = 0;
    srca = 0; srcb = 2'b00; pcs = 2'b10; rs = 2'b00;
    case (p)
      P_F:   begin irw = 1; pcw = 1; srcb = 2'b01; pcs = 2'b00; end
      P_D:   begin aw = 1; bw = 1; aow = 1; srcb = 2'b10; end
      P_MA:  begin srca = 1; srcb = 2'b10; aow = 1; end
      P_MR:  begin mrd = 1; mdrw = 1; end
      P_MWB: begin rgw = 1; rs = 2'b01; end
      P_MW:  begin mwr = 1; end
      P_ER:  begin srca = 1; aow = 1; end
      P_EI:  begin srca = 1; srcb = 2'b10; aow = 1; end
      P_WB:  begin rgw = 1; end
      P_BR:  begin srca = 1; pcs = 2'b01; pcw = (a == b); end
      default: begin rgw = 1; rs = 2'b10; pcw = 1; pcs = 2'b01; end
    endcase
    return {pcw, irw, mrd, mwr, rgw, aw, bw, aow, mdrw, srca, srcb, pcs, rs};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [33:0] ea;
      logic [15:0] act_ctrl;
      ea = model_alu(model_op(exp_phase, bus_if.funct3, bus_if.funct7), bus_if.alu_a, bus_if.alu_b);
      act_ctrl = {bus_if.pc_write, bus_if.ir_write, bus_if.mem_read, bus_if.mem_write,
                  bus_if.reg_write, bus_if.a_write, bus_if.b_write, bus_if.aluout_write,
                  bus_if.mdr_write, bus_if.alu_src_a, bus_if.alu_src_b, bus_if.pc_src,
                  bus_if.result_src};
      check($sformatf("ctrl[%s]", exp_phase.name()), {16'd0, act_ctrl},
            {16'd0, model_ctrl(exp_phase, bus_if.alu_a, bus_if.alu_b)});
      check($sformatf("result[%s]", exp_phase.name()), bus_if.alu_result, ea[31:0]);
      check($sformatf("flags[%s]", exp_phase.name()),
            {28'd0, bus_if.zero, bus_if.carryout, bus_if.negative, bus_if.overflow},
            {28'd0, (ea[31:0] == 32'd0), ea[32], ea[31], ea[33]});
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input bit reset_in_exec);
    phase_t seq[$];
    bus_if.opcode = op;
    bus_if.funct3 = f3;
    bus_if.funct7 = f7;
    bus_if.alu_a  = a;
    bus_if.alu_b  = b;
    seq = '{P_F, P_D};
    case (op)
      7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MWB};
      7'b0100011: seq = '{P_F, P_D, P_MA, P_MW};
      7'b0110011: seq = '{P_F, P_D, P_ER, P_WB};
      7'b0010011: seq = '{P_F, P_D, P_EI, P_WB};
      7'b1100011: seq = '{P_F, P_D, P_BR};
      7'b1101111: seq = '{P_F, P_D, P_J};
      default:    seq = '{P_F, P_D};
    endcase
    foreach (seq[k]) begin
      exp_phase = seq[k];
      if (reset_in_exec && seq[k] == P_ER) begin
        #1 rst = 1'b1;
        exp_phase = P_F;
        #1;
        check("rst_mid_exec", {29'd0, bus_if.ir_write, bus_if.pc_write, bus_if.alu_src_b},
              {29'd0, 1'b1, 1'b1, 2'b01});
        @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      #2;
      if (seq[k] inside {P_ER, P_EI, P_BR, P_MW, P_MR}) begin
        cap_result = bus_if.alu_result;
        cap_zero   = bus_if.zero;
        cap_carry  = bus_if.carryout;
        cap_ovf    = bus_if.overflow;
        cap_pcw    = bus_if.pc_write;
        cap_memw   = bus_if.mem_write;
        cap_mdrw   = bus_if.mdr_write;
      end
      @(posedge clk);
      #1;
    end
    $display("instr op=%b f3=%b f7=%b a=%h b=%h steps=%0d", op, f3, f7, a, b, seq.size());
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  initial begin
    rst = 1'b1;
    bus_if.opcode = 7'd0;
    bus_if.funct3 = 3'd0;
    bus_if.funct7 = 7'd0;
    bus_if.alu_a  = 32'd0;
    bus_if.alu_b  = 32'd0;
    exp_phase = P_F;
    chk_en = 1'b1;
    #3;
    check("reset_fetch", {29'd0, bus_if.ir_write, bus_if.pc_write, bus_if.alu_src_b},
          {29'd0, 1'b1, 1'b1, 2'b01});
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    run_instr(R, 3'b000, 7'b0000000, 32'd7, 32'd5, 0);
    check("add_7_5", cap_result, 32'd12);

    run_instr(R, 3'b000, 7'b0100000, 32'd5, 32'd5, 0);
    check("sub_5_5_zc", {30'd0, cap_zero, cap_carry}, {30'd0, 1'b1, 1'b1});

    run_instr(R, 3'b000, 7'b0100000, 32'h8000_0000, 32'd1, 0);
    check("sub_ovf_res", cap_result, 32'h7FFF_FFFF);
    check("sub_ovf_flag", {31'd0, cap_ovf}, 32'd1);

    run_instr(7'b1100011, 3'b000, 7'd0, 32'd9, 32'd9, 0);
    check("beq_taken", {31'd0, cap_pcw}, 32'd1);
    run_instr(7'b1100011, 3'b000, 7'd0, 32'd9, 32'd8, 0);
    check("beq_not_taken", {31'd0, cap_pcw}, 32'd0);

    run_instr(R, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'd1, 0);
    check("slt_m1_1", cap_result, 32'd1);
    run_instr(R, 3'b011, 7'd0, 32'hFFFF_FFFF, 32'd1, 0);
    check("sltu_max_1", cap_result, 32'd0);
    run_instr(R, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 0);
    check("sra_by4", cap_result, 32'hF800_0000);
    run_instr(R, 3'b101, 7'b0000000, 32'h8000_0000, 32'd4, 0);
    check("srl_by4", cap_result, 32'h0800_0000);

    run_instr(I, 3'b000, 7'b0100000, 32'd10, 32'd3, 0);
    check("addi_ignores_f7", cap_result, 32'd13);

    run_instr(R, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'd1, 0);
    check("add_carry", {30'd0, cap_carry, cap_zero}, {30'd0, 1'b1, 1'b1});

    run_instr(R, 3'b001, 7'd0, 32'h0000_0003, 32'd33, 0);
    run_instr(R, 3'b100, 7'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_instr(I, 3'b110, 7'd0, 32'h1200_0034, 32'h0000_0F00, 0);
    run_instr(I, 3'b111, 7'd0, 32'hDEAD_BEEF, 32'h0000_FFFF, 0);
    run_instr(R, 3'b000, 7'b0100000, 32'd3, 32'd5, 0);

    run_instr(7'b0000011, 3'b010, 7'd0, 32'h100, 32'h20, 0);
    check("lw_mdr_write", {31'd0, cap_mdrw}, 32'd1);
    run_instr(7'b0100011, 3'b010, 7'd0, 32'h100, 32'h24, 0);
    check("sw_mem_write", {31'd0, cap_memw}, 32'd1);
    run_instr(7'b1101111, 3'b000, 7'd0, 32'h40, 32'h8, 0);
    run_instr(7'b1111111, 3'b000, 7'd0, 32'd1, 32'd2, 0);

    run_instr(R, 3'b000, 7'd0, 32'd7, 32'd5, 1);
    run_instr(R, 3'b000, 7'd0, 32'd7, 32'd5, 0);
    check("add_after_reset", cap_result, 32'd12);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
